// File: rtl/tbird_seq_lights.sv
// -----------------------------------------------------------------------------
// tbird_seq_lights
//   Parametrised T-Bird style tail-light sequencer. Animates LAMPS lamps per
//   side for left/right turn requests (lamps fill outward one step at a time)
//   and flashes both sides together for a hazard request. The animation step
//   rate comes from an internal prescaler running on the system clock.
//
//   Optional feature (macro TBIRD_BRAKE_EN): adds brake_i. While braking,
//   every lamp on a side that the current state is not animating is lit.
//
// Parameters
//   LAMPS  lamps per side (2..16)
//   DIV    clocks per animation step (1..65535), 1 = step every clock
//
// Ports
//   clk_i          system clock, rising edge
//   clear_n_i      synchronous active-low reset
//   left_i         left-turn request (level)
//   right_i        right-turn request (level)
//   hazard_i       hazard request (level)
//   brake_i        brake request (level, TBIRD_BRAKE_EN builds only)
//   left_lamps_o   left lamps, bit0 innermost
//   right_lamps_o  right lamps, bit0 innermost
//   busy_o         high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module tbird_seq_lights #(
  parameter int unsigned LAMPS = 3,
  parameter int unsigned DIV   = 1
) (
  input  logic             clk_i,
  input  logic             clear_n_i,
  input  logic             left_i,
  input  logic             right_i,
  input  logic             hazard_i,
`ifdef TBIRD_BRAKE_EN
  input  logic             brake_i,
`endif
  output logic [LAMPS-1:0] left_lamps_o,
  output logic [LAMPS-1:0] right_lamps_o,
  output logic             busy_o
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SW = $clog2(LAMPS + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [SW-1:0] STEP_LAST  = SW'(LAMPS);
  localparam logic [SW-1:0] STEP_FIRST = SW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2,
    ST_HAZ   = 2'd3
  } state_e;

  // State is the animation mode plus the current step k of L(k)/R(k).
  state_e            state_q, state_d;
  logic [SW-1:0]     step_q, step_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [LAMPS-1:0]  left_lamps_q, left_lamps_d;
  logic [LAMPS-1:0]  right_lamps_q, right_lamps_d;
  logic              busy_q, busy_d;

  logic              tick;
  logic              haz_req;
  logic              brake_w;

`ifdef TBIRD_BRAKE_EN
  assign brake_w = brake_i;
`else
  assign brake_w = 1'b0;
`endif

  // Both sides requested together is treated as a hazard.
  assign haz_req = hazard_i | (left_i & right_i);

  // With DIV=1 the prescaler is stuck at 0 and the tick is permanently high.
  assign tick = (presc_q == PRESC_LAST);

  // Low k bits set: the fill pattern for step k.
  function automatic logic [LAMPS-1:0] fill_mask(input logic [SW-1:0] k);
    logic [LAMPS-1:0] m;
    m = '0;
    for (int i = 0; i < int'(LAMPS); i++) begin
      m[i] = (SW'(i) < k);
    end
    return m;
  endfunction

  // State, prescaler and output registers.
  always_ff @(posedge clk_i) begin
    if (!clear_n_i) begin
      state_q       <= ST_IDLE;
      step_q        <= '0;
      presc_q       <= '0;
      left_lamps_q  <= '0;
      right_lamps_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      presc_q       <= presc_d;
      left_lamps_q  <= left_lamps_d;
      right_lamps_q <= right_lamps_d;
      busy_q        <= busy_d;
    end
  end

  // Next state, prescaler and lamp decode of the next state.
  always_comb begin
    state_d       = state_q;
    step_d        = step_q;
    presc_d       = '0;
    left_lamps_d  = '0;
    right_lamps_d = '0;
    busy_d        = 1'b0;

    // Prescaler only runs while animating; it wraps on the tick.
    if (state_q != ST_IDLE && !tick) begin
      presc_d = presc_q + PW'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (haz_req) begin
          state_d = ST_HAZ;
          step_d  = '0;
        end else if (left_i) begin
          state_d = ST_LEFT;
          step_d  = STEP_FIRST;
        end else if (right_i) begin
          state_d = ST_RIGHT;
          step_d  = STEP_FIRST;
        end
      end
      ST_LEFT, ST_RIGHT: begin
        // A running sequence ignores turn requests; only hazard preempts.
        if (tick) begin
          if (haz_req) begin
            state_d = ST_HAZ;
            step_d  = '0;
          end else if (step_q == STEP_LAST) begin
            state_d = ST_IDLE;
            step_d  = '0;
          end else begin
            step_d = step_q + SW'(1);
          end
        end
      end
      ST_HAZ: begin
        // Always drop back to idle so a held hazard flashes on/off.
        if (tick) begin
          state_d = ST_IDLE;
          step_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        step_d  = '0;
      end
    endcase

    unique case (state_d)
      ST_IDLE: begin
        left_lamps_d  = {LAMPS{brake_w}};
        right_lamps_d = {LAMPS{brake_w}};
      end
      ST_LEFT: begin
        left_lamps_d  = fill_mask(step_d);
        right_lamps_d = {LAMPS{brake_w}};
      end
      ST_RIGHT: begin
        left_lamps_d  = {LAMPS{brake_w}};
        right_lamps_d = fill_mask(step_d);
      end
      ST_HAZ: begin
        left_lamps_d  = '1;
        right_lamps_d = '1;
      end
      default: begin
        left_lamps_d  = '0;
        right_lamps_d = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign left_lamps_o  = left_lamps_q;
  assign right_lamps_o = right_lamps_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_tbird_seq_lights.sv
// -----------------------------------------------------------------------------
// tb_tbird_seq_lights
//   Bench for tbird_seq_lights. Two instances: A (LAMPS=3, DIV=1) and
//   B (LAMPS=5, DIV=4) share the same request inputs. A fixed vector table
//   walks A through the turn, hazard, preemption and reset cases; a hand
//   sequence checks B's step timing; a random phase compares both against a
//   reference model that tracks mode and elapsed clocks in that mode.
// -----------------------------------------------------------------------------
module tb_tbird_seq_lights;

  localparam int LA = 3;
  localparam int DA = 1;
  localparam int LB = 5;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic clear_n = 1'b0;
  logic left = 1'b0;
  logic right = 1'b0;
  logic hazard = 1'b0;
  logic brake = 1'b0;

  logic [LA-1:0] a_ll, a_rl;
  logic          a_busy;
  logic [LB-1:0] b_ll, b_rl;
  logic          b_busy;

  always #5 clk = ~clk;

  tbird_seq_lights #(.LAMPS(LA), .DIV(DA)) u_dut_a (
    .clk_i         (clk),
    .clear_n_i     (clear_n),
    .left_i        (left),
    .right_i       (right),
    .hazard_i      (hazard),
`ifdef TBIRD_BRAKE_EN
    .brake_i       (brake),
`endif
    .left_lamps_o  (a_ll),
    .right_lamps_o (a_rl),
    .busy_o        (a_busy)
  );

  tbird_seq_lights #(.LAMPS(LB), .DIV(DB)) u_dut_b (
    .clk_i         (clk),
    .clear_n_i     (clear_n),
    .left_i        (left),
    .right_i       (right),
    .hazard_i      (hazard),
`ifdef TBIRD_BRAKE_EN
    .brake_i       (brake),
`endif
    .left_lamps_o  (b_ll),
    .right_lamps_o (b_rl),
    .busy_o        (b_busy)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: mode 0 idle, 1 left, 2 right, 3 hazard; n = clocks spent
  // in the mode so far. The lit step of a turn sequence is n/div + 1.
  int m_mode[2];
  int m_n[2];
  bit m_brk[2];

  typedef struct {
    bit clr_n;
    bit l;
    bit r;
    bit h;
    int el;
    int er;
    bit eb;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input int c, input int l, input int r, input int h,
                              input int el, input int er, input int eb);
    vec_t v;
    v.clr_n = (c != 0);
    v.l     = (l != 0);
    v.r     = (r != 0);
    v.h     = (h != 0);
    v.el    = el;
    v.er    = er;
    v.eb    = (eb != 0);
    return v;
  endfunction

  task automatic model_edge(input int idx, input int lamps, input int div);
    bit hz;
    hz = hazard || (left && right);
    if (!clear_n) begin
      m_mode[idx] = 0;
      m_n[idx]    = 0;
    end else if (m_mode[idx] == 0) begin
      m_n[idx] = 0;
      if (hz)         m_mode[idx] = 3;
      else if (left)  m_mode[idx] = 1;
      else if (right) m_mode[idx] = 2;
    end else if (((m_n[idx] + 1) % div) != 0) begin
      m_n[idx] = m_n[idx] + 1;
    end else if (m_mode[idx] != 3 && hz) begin
      m_mode[idx] = 3;
      m_n[idx]    = 0;
    end else if (m_mode[idx] == 3 || ((m_n[idx] + 1) / div) >= lamps) begin
      m_mode[idx] = 0;
      m_n[idx]    = 0;
    end else begin
      m_n[idx] = m_n[idx] + 1;
    end
    m_brk[idx] = brake;
  endtask

  function automatic int exp_lamps(input int mode, input int n, input int lamps,
                                   input int div, input bit brk, input bit left_side);
    int full;
    int own;
    full = (1 << lamps) - 1;
    own  = (left_side) ? 1 : 2;
    if (mode == 3) return full;
    if (mode == own) return (1 << (n / div + 1)) - 1;
    return brk ? full : 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic clock_edge();
    @(posedge clk);
    model_edge(0, LA, DA);
    model_edge(1, LB, DB);
    @(negedge clk);
  endtask

  task automatic check_model();
    check("a_left_model",  32'(a_ll),
          exp_lamps(m_mode[0], m_n[0], LA, DA, m_brk[0], 1'b1));
    check("a_right_model", 32'(a_rl),
          exp_lamps(m_mode[0], m_n[0], LA, DA, m_brk[0], 1'b0));
    check("a_busy_model",  32'(a_busy), (m_mode[0] != 0) ? 1 : 0);
    check("b_left_model",  32'(b_ll),
          exp_lamps(m_mode[1], m_n[1], LB, DB, m_brk[1], 1'b1));
    check("b_right_model", 32'(b_rl),
          exp_lamps(m_mode[1], m_n[1], LB, DB, m_brk[1], 1'b0));
    check("b_busy_model",  32'(b_busy), (m_mode[1] != 0) ? 1 : 0);
  endtask

  initial begin
    // clr_n, left, right, hazard -> expected A left, A right, A busy
    // reset, then Left held: 001 011 111 000 001
    vq.push_back(mk(0,0,0,0, 0,0,0));
    vq.push_back(mk(0,0,0,0, 0,0,0));
    vq.push_back(mk(1,1,0,0, 1,0,1));
    vq.push_back(mk(1,1,0,0, 3,0,1));
    vq.push_back(mk(1,1,0,0, 7,0,1));
    vq.push_back(mk(1,1,0,0, 0,0,0));
    vq.push_back(mk(1,1,0,0, 1,0,1));
    // request dropped mid-sequence: completes and stays off
    vq.push_back(mk(1,0,0,0, 3,0,1));
    vq.push_back(mk(1,0,0,0, 7,0,1));
    vq.push_back(mk(1,0,0,0, 0,0,0));
    vq.push_back(mk(1,0,0,0, 0,0,0));
    // hazard preempts R(1), then flashes on/off
    vq.push_back(mk(1,0,1,0, 0,1,1));
    vq.push_back(mk(1,0,0,1, 7,7,1));
    vq.push_back(mk(1,0,0,1, 0,0,0));
    vq.push_back(mk(1,0,0,1, 7,7,1));
    vq.push_back(mk(1,0,0,0, 0,0,0));
    vq.push_back(mk(1,0,0,0, 0,0,0));
    // hazard preempts L(2)
    vq.push_back(mk(1,1,0,0, 1,0,1));
    vq.push_back(mk(1,0,0,0, 3,0,1));
    vq.push_back(mk(1,0,0,1, 7,7,1));
    vq.push_back(mk(1,0,0,0, 0,0,0));
    // Left=Right=1 preempts R(3)
    vq.push_back(mk(1,0,1,0, 0,1,1));
    vq.push_back(mk(1,0,0,0, 0,3,1));
    vq.push_back(mk(1,0,0,0, 0,7,1));
    vq.push_back(mk(1,1,1,0, 7,7,1));
    vq.push_back(mk(1,0,0,0, 0,0,0));
    // opposite side ignored mid-sequence, then starts from idle
    vq.push_back(mk(1,1,0,0, 1,0,1));
    vq.push_back(mk(1,0,1,0, 3,0,1));
    vq.push_back(mk(1,0,1,0, 7,0,1));
    vq.push_back(mk(1,0,1,0, 0,0,0));
    vq.push_back(mk(1,0,1,0, 0,1,1));
    vq.push_back(mk(1,0,0,0, 0,3,1));
    vq.push_back(mk(1,0,0,0, 0,7,1));
    vq.push_back(mk(1,0,0,0, 0,0,0));
    // reset during L(2), Left still held
    vq.push_back(mk(1,1,0,0, 1,0,1));
    vq.push_back(mk(1,1,0,0, 3,0,1));
    vq.push_back(mk(0,1,0,0, 0,0,0));
    vq.push_back(mk(1,1,0,0, 1,0,1));
    // reset during hazard
    vq.push_back(mk(1,1,0,1, 7,7,1));
    vq.push_back(mk(0,0,0,1, 0,0,0));
    vq.push_back(mk(0,0,0,0, 0,0,0));
    vq.push_back(mk(1,1,0,0, 1,0,1));
    vq.push_back(mk(1,0,0,0, 3,0,1));
    vq.push_back(mk(1,0,0,0, 7,0,1));
    vq.push_back(mk(1,0,0,0, 0,0,0));

    @(negedge clk);
    for (int i = 0; i < vq.size(); i++) begin
      clear_n = vq[i].clr_n;
      left    = vq[i].l;
      right   = vq[i].r;
      hazard  = vq[i].h;
      clock_edge();
      check($sformatf("a_left_v%0d", i),  32'(a_ll),   vq[i].el);
      check($sformatf("a_right_v%0d", i), 32'(a_rl),   vq[i].er);
      check($sformatf("a_busy_v%0d", i),  32'(a_busy), 32'(vq[i].eb));
      check_model();
    end

    // B: reset, then a 1-clock Left pulse; each step lasts DB clocks
    clear_n = 1'b0; left = 1'b0; right = 1'b0; hazard = 1'b0;
    clock_edge();
    check("b_reset_left", 32'(b_ll), 0);
    check("b_reset_busy", 32'(b_busy), 0);
    clear_n = 1'b1;
    left    = 1'b1;
    for (int s = 0; s < LB; s++) begin
      for (int c = 0; c < DB; c++) begin
        clock_edge();
        left = 1'b0;
        check($sformatf("b_step%0d_c%0d", s, c), 32'(b_ll), (1 << (s + 1)) - 1);
        check("b_step_right", 32'(b_rl), 0);
      end
    end
    clock_edge();
    check("b_end_left", 32'(b_ll), 0);
    check("b_end_busy", 32'(b_busy), 0);
    left  = 1'b1;
    right = 1'b1;
    clock_edge();
    check("b_lr_left",  32'(b_ll), 31);
    check("b_lr_right", 32'(b_rl), 31);
    left  = 1'b0;
    right = 1'b0;
    for (int c = 0; c < 8; c++) clock_edge();
    check_model();

`ifdef TBIRD_BRAKE_EN
    // brake lights the non-animated side, one clock after assertion
    brake = 1'b1;
    clock_edge();
    check("brk_idle_left",  32'(a_ll), 7);
    check("brk_idle_right", 32'(a_rl), 7);
    left = 1'b1;
    clock_edge();
    left = 1'b0;
    check("brk_l1_left",  32'(a_ll), 1);
    check("brk_l1_right", 32'(a_rl), 7);
    brake = 1'b0;
    for (int c = 0; c < 8; c++) clock_edge();
`endif

    // randomized phase against the model
    for (int c = 0; c < 3000; c++) begin
      clear_n = ($urandom_range(0, 31) != 0);
      hazard  = ($urandom_range(0, 9) == 0);
      left    = ($urandom_range(0, 2) == 0);
      right   = ($urandom_range(0, 2) == 0);
`ifdef TBIRD_BRAKE_EN
      brake   = ($urandom_range(0, 3) == 0);
`endif
      clock_edge();
      check_model();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
